exec_mem_unit: RTL and testbench

//  Execute stage of the PDP8 pipeline. Sits directly downstream of instr_decode.
//  - Consumes pdp_mem_opcode / pdp_op7_opcode.
//  - Executes memory-reference instructions (AND, TAD, ISZ, DCA, JMS, JMP) and OP7 NOP.
//  - Accesses memory through the exec_rd/exec_wr port.
//  - Owns PC and AC/Link. Back-pressures the decoder with stall.

---
 rtl/exec_mem_unit.sv | 164 ++++++++++++++++
 tb/tb_exec_mem_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// Execute stage of the PDP8 pipeline: runs memory-reference instructions and OP7 NOP,
// owns PC, AC and Link, and talks to memory through a single-outstanding rd/wr port.
package exec_mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;

  typedef struct packed {
    logic              nop;
    logic              op_and;
    logic              op_tad;
    logic              op_isz;
    logic              op_dca;
    logic              op_jms;
    logic              op_jmp;
    logic [ADDR_W-1:0] mem_inst_addr;
  } pdp_mem_opcode_t;

  typedef struct packed {
    logic nop;
    logic cla;
    logic cll;
    logic cma;
    logic cml;
    logic iac;
    logic rar;
    logic ral;
    logic rtr;
    logic rtl;
    logic bsw;
    logic sma;
    logic sza;
    logic snl;
    logic skp;
    logic osr;
    logic hlt;
  } pdp_op7_opcode_t;
endpackage

module exec_mem_unit
  import exec_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_t       pdp_mem_opcode,
  input  pdp_op7_opcode_t       pdp_op7_opcode,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  exec_rd_req,
  output logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_wr_req,
  output logic [ADDR_WIDTH-1:0] exec_wr_addr,
  output logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic                  link_out
);

  typedef enum logic [2:0] {INIT, IDLE, RD, RD_WAIT, WR, DONE} state_t;
  typedef enum logic [2:0] {OP_AND, OP_TAD, OP_ISZ, OP_DCA, OP_JMS, OP_JMP} op_t;

  state_t                state;
  op_t                   op;
  logic [ADDR_WIDTH-1:0] ea;
  logic [DATA_WIDTH-1:0] md;
  logic [DATA_WIDTH:0]   tad_sum;
  logic                  mem_hit;

  assign tad_sum = {1'b0, ac_out} + {1'b0, exec_rd_data};
  assign mem_hit = pdp_mem_opcode.op_and | pdp_mem_opcode.op_tad | pdp_mem_opcode.op_isz |
                   pdp_mem_opcode.op_dca | pdp_mem_opcode.op_jms | pdp_mem_opcode.op_jmp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= INIT;
      op           <= OP_AND;
      ea           <= '0;
      md           <= '0;
      stall        <= 1'b1;
      PC_value     <= '0;
      exec_rd_req  <= 1'b0;
      exec_rd_addr <= '0;
      exec_wr_req  <= 1'b0;
      exec_wr_addr <= '0;
      exec_wr_data <= '0;
      ac_out       <= '0;
      link_out     <= 1'b0;
    end else begin
      exec_rd_req <= 1'b0;
      exec_wr_req <= 1'b0;
      case (state)
        INIT: begin
          PC_value <= base_addr;
          stall    <= 1'b0;
          state    <= IDLE;
        end
        IDLE: begin
          if (mem_hit) begin
            stall <= 1'b1;
            ea    <= pdp_mem_opcode.mem_inst_addr;
            // Priority chain resolves illegal multi-flag encodings deterministically.
            if (pdp_mem_opcode.op_and || pdp_mem_opcode.op_tad || pdp_mem_opcode.op_isz) begin
              op           <= pdp_mem_opcode.op_and ? OP_AND :
                              pdp_mem_opcode.op_tad ? OP_TAD : OP_ISZ;
              exec_rd_req  <= 1'b1;
              exec_rd_addr <= pdp_mem_opcode.mem_inst_addr;
              state        <= RD;
            end else if (pdp_mem_opcode.op_dca || pdp_mem_opcode.op_jms) begin
              op           <= pdp_mem_opcode.op_dca ? OP_DCA : OP_JMS;
              exec_wr_req  <= 1'b1;
              exec_wr_addr <= pdp_mem_opcode.mem_inst_addr;
              exec_wr_data <= pdp_mem_opcode.op_dca ? ac_out : (PC_value + 1'b1);
              state        <= WR;
            end else begin
              op    <= OP_JMP;
              state <= DONE;
            end
          end else if (pdp_mem_opcode.nop || (|pdp_op7_opcode)) begin
            PC_value <= PC_value + 1'b1;
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          md    <= exec_rd_data;
          state <= DONE;
          case (op)
            OP_AND: ac_out <= ac_out & exec_rd_data;
            OP_TAD: begin
              ac_out   <= tad_sum[DATA_WIDTH-1:0];
              link_out <= link_out ^ tad_sum[DATA_WIDTH];
            end
            OP_ISZ: begin
              md           <= exec_rd_data + 1'b1;
              exec_wr_req  <= 1'b1;
              exec_wr_addr <= ea;
              exec_wr_data <= exec_rd_data + 1'b1;
              state        <= WR;
            end
            default: ;
          endcase
        end
        WR: begin
          if (op == OP_DCA) ac_out <= '0;
          state <= DONE;
        end
        DONE: begin
          case (op)
            OP_JMP:  PC_value <= ea;
            OP_JMS:  PC_value <= ea + 1'b1;
            OP_ISZ:  PC_value <= (md == '0) ? (PC_value + 2'd2) : (PC_value + 1'b1);
            default: PC_value <= PC_value + 1'b1;
          endcase
          stall <= 1'b0;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: behavioural memory, hand-computed PC/AC/L/write results.
module tb_exec_mem_unit;
  import exec_mem_pkg::*;

  localparam int K_AND = 0, K_TAD = 1, K_ISZ = 2, K_DCA = 3, K_JMS = 4, K_JMP = 5, K_NOP = 6, K_OP7 = 7;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [11:0]     base_addr;
  pdp_mem_opcode_t mem_op;
  pdp_op7_opcode_t op7_op;
  logic            stall;
  logic [11:0]     pc_value;
  logic            rd_req, wr_req;
  logic [11:0]     rd_addr, wr_addr, wr_data, ac, rd_data;
  logic            link;

  logic [11:0] mem [4096];
  int          wr_cnt = 0;
  int          overlap = 0;
  logic [11:0] last_wr_addr = '0;
  logic [11:0] last_wr_data = '0;
  int          checks = 0;
  int          errors = 0;
  int          wr_before;

  always #5 clk = ~clk;

  exec_mem_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .base_addr      (base_addr),
    .pdp_mem_opcode (mem_op),
    .pdp_op7_opcode (op7_op),
    .stall          (stall),
    .PC_value       (pc_value),
    .exec_rd_req    (rd_req),
    .exec_rd_addr   (rd_addr),
    .exec_rd_data   (rd_data),
    .exec_wr_req    (wr_req),
    .exec_wr_addr   (wr_addr),
    .exec_wr_data   (wr_data),
    .ac_out         (ac),
    .link_out       (link)
  );

  always @(posedge clk) begin
    if (rd_req) rd_data <= mem[rd_addr];
    if (wr_req) begin
      mem[wr_addr] <= wr_data;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
    if (rd_req && wr_req) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end else begin
      $display("ok   %s: %0o", tag, got);
    end
  endtask

  // Pulse one instruction in IDLE, then count cycles until stall drops.
  task automatic do_op(input int kind, input logic [11:0] ea, input int exp_lat, input string tag);
    pdp_mem_opcode_t m;
    pdp_op7_opcode_t o;
    int n;
    @(negedge clk);
    wr_before = wr_cnt;
    m = '0;
    o = '0;
    m.mem_inst_addr = ea;
    case (kind)
      K_AND: m.op_and = 1'b1;
      K_TAD: m.op_tad = 1'b1;
      K_ISZ: m.op_isz = 1'b1;
      K_DCA: m.op_dca = 1'b1;
      K_JMS: m.op_jms = 1'b1;
      K_JMP: m.op_jmp = 1'b1;
      K_NOP: m.nop    = 1'b1;
      default: o.iac  = 1'b1;
    endcase
    mem_op = m;
    op7_op = o;
    @(posedge clk);
    #1;
    mem_op = '0;
    op7_op = '0;
    n = 1;
    while (stall && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
  endtask

  task automatic expect_state(input string tag, input logic [11:0] pc, input logic [11:0] a, input logic l);
    check({tag, " PC"}, pc_value, pc);
    check({tag, " AC"}, ac, a);
    check({tag, " L"}, link, l);
  endtask

  task automatic expect_wr(input string tag, input int cnt, input logic [11:0] a, input logic [11:0] d);
    check({tag, " wr count"}, wr_cnt - wr_before, cnt);
    if (cnt != 0) begin
      check({tag, " wr addr"}, last_wr_addr, a);
      check({tag, " wr data"}, last_wr_data, d);
    end
  endtask

  initial begin
    mem_op    = '0;
    op7_op    = '0;
    rd_data   = '0;
    base_addr = 12'o0200;
    reset_n   = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'o0100] = 12'o7777;
    mem[12'o0101] = 12'o0001;
    mem[12'o0102] = 12'o1234;
    mem[12'o0050] = 12'o7777;
    mem[12'o0051] = 12'o0005;
    mem[12'o0052] = 12'o7777;
    mem[12'o0070] = 12'o0707;

    repeat (3) @(posedge clk);
    #1;
    check("reset stall", stall, 1);
    check("reset rd_req", rd_req, 0);
    check("reset wr_req", wr_req, 0);
    expect_state("reset", 12'o0000, 12'o0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("init stall", stall, 1);
    @(posedge clk);
    #1;
    check("post-init stall", stall, 0);
    check("post-init PC", pc_value, 12'o0200);

    do_op(K_TAD, 12'o0100, 4, "TAD 7777");
    expect_state("TAD 7777", 12'o0201, 12'o7777, 1'b0);
    do_op(K_TAD, 12'o0101, 4, "TAD carry");
    expect_state("TAD carry", 12'o0202, 12'o0000, 1'b1);
    expect_wr("TAD carry", 0, 0, 0);
    do_op(K_TAD, 12'o0102, 4, "TAD 1234");
    expect_state("TAD 1234", 12'o0203, 12'o1234, 1'b1);
    do_op(K_DCA, 12'o0060, 3, "DCA");
    expect_state("DCA", 12'o0204, 12'o0000, 1'b1);
    expect_wr("DCA", 1, 12'o0060, 12'o1234);
    do_op(K_ISZ, 12'o0050, 5, "ISZ skip");
    expect_wr("ISZ skip", 1, 12'o0050, 12'o0000);
    check("ISZ skip PC", pc_value, 12'o0206);
    do_op(K_ISZ, 12'o0051, 5, "ISZ noskip");
    expect_wr("ISZ noskip", 1, 12'o0051, 12'o0006);
    check("ISZ noskip PC", pc_value, 12'o0207);
    do_op(K_TAD, 12'o0100, 4, "TAD reload");
    do_op(K_AND, 12'o0070, 4, "AND");
    expect_state("AND", 12'o0211, 12'o0707, 1'b1);

    do_op(K_JMP, 12'o0300, 2, "JMP 0300");
    check("JMP 0300 PC", pc_value, 12'o0300);
    do_op(K_JMS, 12'o0400, 3, "JMS");
    expect_wr("JMS", 1, 12'o0400, 12'o0301);
    check("JMS PC", pc_value, 12'o0401);
    do_op(K_JMP, 12'o7777, 2, "JMP 7777");
    check("JMP 7777 PC", pc_value, 12'o7777);
    do_op(K_NOP, 12'o0000, 1, "NOP wrap");
    check("NOP wrap PC", pc_value, 12'o0000);
    do_op(K_OP7, 12'o0000, 1, "OP7 IAC");
    expect_state("OP7 IAC", 12'o0001, 12'o0707, 1'b1);
    do_op(K_JMP, 12'o7777, 2, "JMP 7777 again");
    do_op(K_ISZ, 12'o0052, 5, "ISZ wrap");
    check("ISZ wrap PC", pc_value, 12'o0001);
    check("rd/wr overlap", overlap, 0);

    // AND interrupted by reset while waiting for read data.
    @(negedge clk);
    wr_before = wr_cnt;
    mem_op = '0;
    mem_op.op_and = 1'b1;
    mem_op.mem_inst_addr = 12'o0070;
    @(posedge clk);
    #1;
    mem_op = '0;
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    base_addr = 12'o0500;
    #1;
    check("midop stall", stall, 1);
    check("midop rd_req", rd_req, 0);
    check("midop wr_req", wr_req, 0);
    expect_state("midop", 12'o0000, 12'o0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("re-init PC", pc_value, 12'o0500);
    check("re-init stall", stall, 0);
    repeat (3) @(posedge clk);
    #1;
    expect_wr("midop", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
